// File: rtl/button_event_gen.sv
// ---------------------------------------------------------------------------
// button_event_gen
//
// Turns a debounced, active-low button level into press, release, long-press
// and auto-repeat event pulses. It also provides a "held" level for the
// duration of an accepted press.
//
// A press is accepted only after the line has been seen released at least
// once since reset. This keeps a button that is already down at power-up
// from producing a spurious press.
//
// Parameters
//   LONG_CYCLES   cycles from the press edge to the long_press pulse (>= 2)
//   REPEAT_CYCLES cycles between repeat pulses once long-pressed     (>= 2)
//   CNT_WIDTH     hold counter width; must hold max(LONG,REPEAT)-1
//
// Ports
//   clk_i         clock, rising-edge active
//   reset_ni      asynchronous active-low reset
//   line_i        debounced button level, 1 = released, 0 = pressed
//   press_o       one-cycle pulse on an accepted press
//   release_o     one-cycle pulse on release after an accepted press
//   long_press_o  one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_o      one-cycle pulse every REPEAT_CYCLES after long_press
//   held_o        level, high while an accepted press is in progress
//
// The release and repeat ports carry suffixes so that they do not collide
// with the Verilog keywords of the same name.
// ---------------------------------------------------------------------------
module button_event_gen #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_WIDTH     = 32
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic line_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } state_e;

    // Terminal counts. The counter restarts at zero on every threshold, so
    // it never exceeds the active threshold minus one and never wraps.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 press_q;
    logic                 release_q;
    logic                 long_press_q;
    logic                 repeat_q;
    logic                 held_q;

    // Event FSM with hold counter; every output is registered here.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_LOCKOUT;
            cnt_q        <= CNT_ZERO;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            // Pulses default low so that each one lasts exactly one cycle.
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
            case (state_q)
                ST_LOCKOUT: begin
                    held_q <= 1'b0;
                    if (line_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_LOCKOUT;
                    end
                end
                ST_IDLE: begin
                    if (!line_i) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= CNT_ZERO;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        held_q  <= 1'b0;
                    end
                end
                ST_PRESSED: begin
                    // Release is checked first, so it wins over a
                    // threshold that is reached on the same edge.
                    if (line_i) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q      <= ST_HELD;
                        cnt_q        <= CNT_ZERO;
                        long_press_q <= 1'b1;
                        held_q       <= 1'b1;
                    end else begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= cnt_q + CNT_ONE;
                        held_q  <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (line_i) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        state_q  <= ST_HELD;
                        cnt_q    <= CNT_ZERO;
                        repeat_q <= 1'b1;
                        held_q   <= 1'b1;
                    end else begin
                        state_q <= ST_HELD;
                        cnt_q   <= cnt_q + CNT_ONE;
                        held_q  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe state.
                    state_q <= ST_LOCKOUT;
                    cnt_q   <= CNT_ZERO;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_press_q;
    assign repeat_o     = repeat_q;
    assign held_o       = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// ---------------------------------------------------------------------------
// tb_button_event_gen
//
// Directed bench for button_event_gen, with LONG_CYCLES=8 and
// REPEAT_CYCLES=4. Each step drives the line and pushes the expected output
// vector {press, release, long_press, repeat, held} onto a queue. After the
// clock edge the vector is popped and compared with the outputs.
// ---------------------------------------------------------------------------
module tb_button_event_gen;

    logic clk;
    logic reset_n;
    logic line;
    logic press;
    logic release_p;
    logic long_press;
    logic repeat_p;
    logic held;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];

    button_event_gen #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_WIDTH    (8)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .line_i      (line),
        .press_o     (press),
        .release_o   (release_p),
        .long_press_o(long_press),
        .repeat_o    (repeat_p),
        .held_o      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {press, release_p, long_press, repeat_p, held};
    endfunction

    function automatic logic [4:0] ev(input logic p, input logic r,
                                      input logic l, input logic rp,
                                      input logic h);
        return {p, r, l, rp, h};
    endfunction

    // Pop one expected vector and compare it with the current outputs.
    task automatic check_now(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        if (exp_q.size() == 0) begin
            e = 5'b11111;
        end else begin
            e = exp_q.pop_front();
        end
        o = outs();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Drive the line, push the expectation, let one edge pass and compare.
    task automatic step(input logic l, input logic [4:0] e, input string tag);
        line = l;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        line    = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(5'b00000);
        check_now("reset_state");
        reset_n = 1'b1;

        // Idle stability: the line stays released for 1000 cycles.
        for (int i = 0; i < 1000; i++) step(1'b1, 5'b00000, "idle_stable");

        // Short press: the line is low for 5 edges, then released.
        for (int i = 0; i <= 5; i++)
            step((i < 5) ? 1'b0 : 1'b1,
                 ev(i == 0, i == 5, 1'b0, 1'b0, i < 5), "short_press");
        step(1'b1, 5'b00000, "short_after");

        // Long hold: the line is low on edges 0..19, then released at 20.
        for (int i = 0; i <= 20; i++)
            step((i < 20) ? 1'b0 : 1'b1,
                 ev(i == 0, i == 20, i == 8, (i == 12) || (i == 16), i < 20),
                 "long_hold");
        step(1'b1, 5'b00000, "long_after");

        // Threshold race: the release coincides with the long-press count.
        for (int i = 0; i <= 8; i++)
            step((i < 8) ? 1'b0 : 1'b1,
                 ev(i == 0, i == 8, 1'b0, 1'b0, i < 8), "threshold_race");
        step(1'b1, 5'b00000, "race_after");

        // Reach HELD: press@0, long_press@8, then held at edge 9.
        for (int i = 0; i <= 9; i++)
            step(1'b0, ev(i == 0, 1'b0, i == 8, 1'b0, 1'b1), "to_held");

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(5'b00000);
        check_now("async_reset");
        step(1'b0, 5'b00000, "in_reset");
        reset_n = 1'b1;

        // Lockout: the line is still low after reset, so no events occur.
        for (int i = 0; i < 10; i++) step(1'b0, 5'b00000, "lockout");
        step(1'b1, 5'b00000, "unlock");
        step(1'b0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "press_after_lock");
        step(1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "held_after_lock");
        step(1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "release_after_lock");
        step(1'b1, 5'b00000, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 The block SHALL have the parameter LONG_CYCLES, default 25000000: cycles from press to long_press pulse (legal values >= 2).
REQ-002 The block SHALL have the parameter REPEAT_CYCLES, default 5000000: cycles between successive repeat pulses (legal values >= 2).
REQ-003 The block SHALL have the parameter CNT_WIDTH, default 32: width of the internal hold counter, which SHALL hold max(LONG_CYCLES, REPEAT_CYCLES)-1.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port line, input, 1 bit: debounced button level, synchronous to clk; 1 = released, 0 = pressed.
REQ-007 The block SHALL have the port press, output, 1 bit: one-cycle pulse on the accepted press.
REQ-008 The block SHALL have the port release, output, 1 bit: one-cycle pulse on release after an accepted press.
REQ-009 The block SHALL have the port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-010 The block SHALL have the port repeat, output, 1 bit: one-cycle pulse every REPEAT_CYCLES after long_press while still held.
REQ-011 The block SHALL have the port held, output, 1 bit: level, 1 while an accepted press is in progress.

Function
REQ-012 The block SHALL implement the states LOCKOUT, IDLE, PRESSED and HELD, with a hold counter cnt.
REQ-013 All outputs SHALL be registered, and each pulse SHALL be high for exactly one cycle, starting after the edge that sampled the triggering line value.
REQ-014 LOCKOUT: line=1 -> IDLE; line=0 -> stay; no pulse in either case.
REQ-015 IDLE: line=0 -> PRESSED, press=1, cnt=0; line=1 -> stay.
REQ-016 PRESSED: line=1 -> IDLE, release=1; otherwise, if cnt==LONG_CYCLES-1 -> HELD, long_press=1, cnt=0; otherwise cnt=cnt+1.
REQ-017 HELD: line=1 -> IDLE, release=1; otherwise, if cnt==REPEAT_CYCLES-1 -> repeat=1, cnt=0 (stay HELD); otherwise cnt=cnt+1.
REQ-018 long_press SHALL occur exactly LONG_CYCLES edges after the press edge.
REQ-019 The first repeat SHALL occur exactly REPEAT_CYCLES edges after long_press, and each later repeat REPEAT_CYCLES edges after the previous one.
REQ-020 Release SHALL take priority: on an edge where line=1 and cnt is at threshold, only release SHALL pulse.
REQ-021 At most one of press, release, long_press and repeat SHALL be high in any cycle.
REQ-022 held SHALL be 1 exactly while the state is PRESSED or HELD, as a registered output.
REQ-023 cnt SHALL never exceed its threshold minus 1 and SHALL never wrap.
REQ-024 Repeat SHALL continue indefinitely while line=0 in HELD.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force state=LOCKOUT, cnt=0 and press=release=long_press=repeat=held=0.
REQ-026 After reset deasserts, no press SHALL be reported until line has been sampled 1 at least once (LOCKOUT).
REQ-027 Reset asserted mid-press SHALL discard the press without a release pulse.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-028 Short press: from IDLE, line=0 for 5 edges then 1 -> press at edge 0, held=1 for 5 cycles, release at edge 5, no long_press/repeat.
REQ-029 Long hold: line=0 on edges 0..19, 1 at edge 20 -> press@0, long_press@8, repeat@12 and @16, release@20; 2 repeats total.
REQ-030 Threshold race: line=0 on edges 0..7, 1 at edge 8 -> press@0, release@8, long_press never asserted.
REQ-031 Lockout: reset released with line=0 for 10 cycles -> no pulses, held=0; then line=1 for 1 cycle, then 0 -> press one cycle later.
REQ-032 Reset mid-hold: in HELD, reset=0 mid-cycle -> all outputs 0 before the next edge; deassert with line=0 -> no release, no press until line=1 then 0.
REQ-033 Idle stability: line=1 for 1000 cycles after reset -> all outputs remain 0.
